// File: rtl/mac_mmio_stream.sv
// Streaming multiply-accumulate engine: accepts (x, y) operand beats over a
// valid/ready handshake, accumulates their dot product with saturation, and
// presents the result (acc, count, overflow) until the consumer takes it.
module mac_mmio_stream #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 input_ready,
    input  logic                 input_valid,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 last,
    input  logic                 is_signed,
    input  logic                 output_ready,
    output logic                 output_valid,
    output logic [ACC_WIDTH-1:0] acc,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow,
    output logic                 busy
);

    localparam int unsigned PROD_WIDTH = 2 * WIDTH;
    localparam int unsigned SUM_WIDTH  = ACC_WIDTH + 1;
    localparam int unsigned EXT_WIDTH  = SUM_WIDTH - PROD_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   mode_q;
    logic                   p1_valid;
    logic [PROD_WIDTH-1:0]  p1_prod;

    logic                   beat;
    logic                   mode_now;
    logic [PROD_WIDTH-1:0]  prod_c;
    logic [SUM_WIDTH-1:0]   acc_ext;
    logic [SUM_WIDTH-1:0]   prod_ext;
    logic [SUM_WIDTH-1:0]   sum;
    logic                   sum_ovf;
    logic [ACC_WIDTH-1:0]   clamp_val;
    logic [ACC_WIDTH-1:0]   sum_clamped;

    assign beat     = input_valid && input_ready;
    // The first beat of a vector multiplies in the mode being latched alongside it.
    assign mode_now = (state == S_IDLE) ? is_signed : mode_q;

    // Stage-1 product: operands sign- or zero-extended to full product width.
    always_comb begin
        prod_c = '0;
        if (mode_now) begin
            prod_c = {{WIDTH{x[WIDTH-1]}}, x} * {{WIDTH{y[WIDTH-1]}}, y};
        end else begin
            prod_c = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
        end
    end

    // Stage-2 add with one guard bit, then clamp to the representable range.
    always_comb begin
        acc_ext   = '0;
        prod_ext  = '0;
        sum       = '0;
        sum_ovf   = 1'b0;
        clamp_val = '1;
        if (mode_q) begin
            acc_ext  = {acc[ACC_WIDTH-1], acc};
            prod_ext = {{EXT_WIDTH{p1_prod[PROD_WIDTH-1]}}, p1_prod};
        end else begin
            acc_ext  = {1'b0, acc};
            prod_ext = {{EXT_WIDTH{1'b0}}, p1_prod};
        end
        sum = acc_ext + prod_ext;
        if (mode_q) begin
            sum_ovf   = sum[SUM_WIDTH-1] ^ sum[SUM_WIDTH-2];
            clamp_val = sum[SUM_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            sum_ovf   = sum[SUM_WIDTH-1];
            clamp_val = '1;
        end
        sum_clamped = sum_ovf ? clamp_val : sum[ACC_WIDTH-1:0];
    end

    // Next-state decode; DRAIN waits for the final product to reach stage 2.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (beat) state_nxt = last ? S_DRAIN : S_ACCUM;
            S_ACCUM: if (beat && last) state_nxt = S_DRAIN;
            S_DRAIN: if (p1_valid) state_nxt = S_DONE;
            S_DONE:  if (output_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register with handshake/status flags registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            mode_q       <= 1'b0;
            input_ready  <= 1'b1;
            output_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            input_ready  <= (state_nxt == S_IDLE) || (state_nxt == S_ACCUM);
            output_valid <= (state_nxt == S_DONE);
            busy         <= (state_nxt != S_IDLE);
            if ((state == S_IDLE) && beat) begin
                mode_q <= is_signed;
            end
        end
    end

    // Datapath: product pipeline, saturating accumulator and beat counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p1_valid <= 1'b0;
            p1_prod  <= '0;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            p1_valid <= beat;
            if (beat) begin
                p1_prod <= prod_c;
            end
            if ((state == S_IDLE) && beat) begin
                acc      <= '0;
                count    <= CNT_WIDTH'(1);
                overflow <= 1'b0;
            end else begin
                if (beat && (count != {CNT_WIDTH{1'b1}})) begin
                    count <= count + CNT_WIDTH'(1);
                end
                if (p1_valid) begin
                    acc <= sum_clamped;
                    if (sum_ovf) begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_mmio_stream.sv
// Scoreboard bench for mac_mmio_stream: directed vectors push expected results,
// a negedge monitor checks latency and result contents at each handshake.
module tb_mac_mmio_stream;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned ACC_WIDTH = 32;
    localparam int unsigned CNT_WIDTH = 8;

    logic                 clock;
    logic                 reset;
    logic                 input_ready;
    logic                 input_valid;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 last;
    logic                 is_signed;
    logic                 output_ready;
    logic                 output_valid;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] count;
    logic                 overflow;
    logic                 busy;

    mac_mmio_stream #(
        .WIDTH    (WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .input_ready (input_ready),
        .input_valid (input_valid),
        .x           (x),
        .y           (y),
        .last        (last),
        .is_signed   (is_signed),
        .output_ready(output_ready),
        .output_valid(output_valid),
        .acc         (acc),
        .count       (count),
        .overflow    (overflow),
        .busy        (busy)
    );

    typedef struct {
        logic [ACC_WIDTH-1:0] acc;
        logic [CNT_WIDTH-1:0] cnt;
        logic                 ovf;
        int                   edge_no;
    } exp_t;

    exp_t           exp_q[$];
    logic [WIDTH-1:0] vx[$];
    logic [WIDTH-1:0] vy[$];
    int             vgap[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic           prev_valid = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: first valid cycle must be last-accept edge + 1; compare at handshake.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (output_valid && !prev_valid) begin
                if (exp_q.size() == 0) chk("spurious_valid", 64'(output_valid), 64'd0);
                else chk("latency", 64'(cyc), 64'(exp_q[0].edge_no + 1));
            end
            if (output_valid && output_ready && exp_q.size() > 0) begin
                chk("result_acc", 64'(acc), 64'(exp_q[0].acc));
                chk("result_count", 64'(count), 64'(exp_q[0].cnt));
                chk("result_overflow", 64'(overflow), 64'(exp_q[0].ovf));
                void'(exp_q.pop_front());
            end
            prev_valid = output_valid;
        end
    end

    task automatic add_beat(input logic [WIDTH-1:0] bx, input logic [WIDTH-1:0] by, input int gap);
        vx.push_back(bx);
        vy.push_back(by);
        vgap.push_back(gap);
    endtask

    // Offer one beat after 'gap' idle cycles; returns the edge that accepts it.
    task automatic send_beat(input logic [WIDTH-1:0] bx, input logic [WIDTH-1:0] by,
                             input logic bl, input logic bs, input int gap, output int edge_no);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            input_valid = 1'b0;
        end
        @(negedge clock);
        x = bx; y = by; last = bl; is_signed = bs; input_valid = 1'b1;
        n = 0;
        while (!input_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            chk("input_ready_timeout", 64'(input_ready), 64'd1);
            input_valid = 1'b0;
            edge_no = -1;
        end else begin
            edge_no = cyc + 1;
            @(posedge clock);
        end
    endtask

    // Send queued beats as one vector; later beats carry the opposite is_signed.
    task automatic send_vec(input logic sgn, input logic [ACC_WIDTH-1:0] eacc,
                            input logic [CNT_WIDTH-1:0] ecnt, input logic eovf);
        int   e;
        exp_t item;
        e = -1;
        for (int i = 0; i < vx.size(); i++) begin
            send_beat(vx[i], vy[i], (i == vx.size() - 1), (i == 0) ? sgn : !sgn, vgap[i], e);
        end
        item.acc = eacc; item.cnt = ecnt; item.ovf = eovf; item.edge_no = e;
        exp_q.push_back(item);
        @(negedge clock);
        input_valid = 1'b0;
        last = 1'b0;
        vx.delete(); vy.delete(); vgap.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle_pending", 64'(exp_q.size()), 64'd0);
        chk("wait_idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int n;
        reset = 1'b1; output_ready = 1'b1; input_valid = 1'b0;
        x = '0; y = '0; last = 1'b0; is_signed = 1'b0;
        #12;
        chk("reset_acc", 64'(acc), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_input_ready", 64'(input_ready), 64'd1);
        chk("reset_output_valid", 64'(output_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single unsigned beat 3*5.
        add_beat(16'd3, 16'd5, 0);
        send_vec(1'b0, 32'd15, 8'd1, 1'b0);
        wait_idle();

        // Signed (-2,3),(4,5),(-1,-1): -6+20+1.
        add_beat(16'hFFFE, 16'd3, 0); add_beat(16'd4, 16'd5, 0); add_beat(16'hFFFF, 16'hFFFF, 0);
        send_vec(1'b1, 32'd15, 8'd3, 1'b0);
        wait_idle();

        // Unsigned 0xFFFE*3 + 4*5 + 1*1.
        add_beat(16'hFFFE, 16'd3, 0); add_beat(16'd4, 16'd5, 0); add_beat(16'd1, 16'd1, 0);
        send_vec(1'b0, 32'h0003_000F, 8'd3, 1'b0);
        wait_idle();

        // Signed positive saturation: 3 x 0x3FFF0001.
        for (int i = 0; i < 3; i++) add_beat(16'h7FFF, 16'h7FFF, 0);
        send_vec(1'b1, 32'h7FFF_FFFF, 8'd3, 1'b1);
        wait_idle();

        // Signed negative saturation: 3 x -0x3FFF8000.
        for (int i = 0; i < 3; i++) add_beat(16'h8000, 16'h7FFF, 0);
        send_vec(1'b1, 32'h8000_0000, 8'd3, 1'b1);
        wait_idle();

        // Unsigned saturation: 2 x 0xFFFE0001.
        add_beat(16'hFFFF, 16'hFFFF, 0); add_beat(16'hFFFF, 16'hFFFF, 0);
        send_vec(1'b0, 32'hFFFF_FFFF, 8'd2, 1'b1);
        wait_idle();

        // Overflow stays sticky after the accumulator comes back into range.
        for (int i = 0; i < 3; i++) add_beat(16'h7FFF, 16'h7FFF, 0);
        add_beat(16'h8000, 16'h7FFF, 0);
        send_vec(1'b1, 32'h4000_7FFF, 8'd4, 1'b1);
        wait_idle();

        // Consumer stall: result must hold for 5 cycles, then release.
        @(posedge clock); #1 output_ready = 1'b0;
        add_beat(16'd6, 16'd7, 0);
        send_vec(1'b0, 32'd42, 8'd1, 1'b0);
        n = 0;
        while (!output_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("stall_valid_seen", 64'(output_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_acc", 64'(acc), 64'd42);
            chk("stall_input_ready", 64'(input_ready), 64'd0);
            chk("stall_busy", 64'(busy), 64'd1);
        end
        @(posedge clock); #1 output_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("release_input_ready", 64'(input_ready), 64'd1);
        chk("release_busy", 64'(busy), 64'd0);
        chk("release_output_valid", 64'(output_valid), 64'd0);
        wait_idle();

        // Reset pulse after 2 of 4 beats discards the partial vector.
        send_beat(16'd2, 16'd3, 1'b0, 1'b0, 0, e);
        send_beat(16'd4, 16'd5, 1'b0, 1'b0, 0, e);
        @(negedge clock);
        input_valid = 1'b0;
        @(negedge clock);
        chk("partial_acc", 64'(acc), 64'd26);
        chk("partial_count", 64'(count), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("midreset_acc", 64'(acc), 64'd0);
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_input_ready", 64'(input_ready), 64'd1);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_output_valid", 64'(output_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        add_beat(16'd7, 16'd7, 0);
        send_vec(1'b0, 32'd49, 8'd1, 1'b0);
        wait_idle();

        // Gapped 4-beat vector of (1,1).
        for (int i = 0; i < 4; i++) add_beat(16'd1, 16'd1, 1);
        send_vec(1'b0, 32'd4, 8'd4, 1'b0);
        wait_idle();

        // Count saturates at 255 while acc keeps summing; no overflow.
        for (int i = 0; i < 258; i++) add_beat(16'd1, 16'd1, 0);
        send_vec(1'b0, 32'd258, 8'd255, 1'b0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
